// File: rtl/up_down_counter.sv
// up_down_counter: WIDTH-bit binary up/down counter that steps once per clock.
//
// Direction is chosen each cycle by up_down. By default the count wraps
// modulo 2^WIDTH. When the macro UP_DOWN_COUNTER_SAT_EN is defined, it
// saturates at 0 and at the maximum value instead.
//
// Parameters
//   WIDTH        counter width in bits (2..32)
//   RESET_VALUE  value loaded into the counter while reset is low
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset (0 = in reset)
//   up_down  in   1 = count up, 0 = count down
//   counter  out  registered count value
//   at_max   out  combinational, counter is all ones
//   at_min   out  combinational, counter is zero
//   wrap     out  registered one-cycle pulse after a wrap or blocked step
module up_down_counter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_down,
  output logic [WIDTH-1:0] counter,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_VAL = '0;
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

  // Catch illegal parameterisation at elaboration time
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("up_down_counter: WIDTH must be in 2..32");
  end

  logic             boundary;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] counter_next;

  // Status flags decoded straight from the count register
  always_comb begin
    at_max = (counter == MAX_VAL);
    at_min = (counter == MIN_VAL);
  end

  // Next-count logic. boundary marks a step that would cross the range end.
  always_comb begin
    boundary     = up_down ? at_max : at_min;
    step_val     = up_down ? (counter + WIDTH'(1)) : (counter - WIDTH'(1));
`ifdef UP_DOWN_COUNTER_SAT_EN
    counter_next = boundary ? counter : step_val;
`else
    counter_next = step_val;
`endif
  end

  // Count and wrap-pulse registers. Reset clears any pending wrap pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter <= RST_VAL;
      wrap    <= 1'b0;
    end else begin
      counter <= counter_next;
      wrap    <= boundary;
    end
  end

endmodule

// File: tb/tb_up_down_counter.sv
// tb_up_down_counter: directed self-checking bench for up_down_counter
// (WIDTH=4, RESET_VALUE=0). Expectations follow UP_DOWN_COUNTER_SAT_EN
// when that macro is defined for the build.
module tb_up_down_counter;

  logic       clk;
  logic       reset;
  logic       up_down;
  logic [3:0] counter;
  logic       at_max;
  logic       at_min;
  logic       wrap;

  int n_checks;
  int n_fail;

  up_down_counter #(
    .WIDTH       (4),
    .RESET_VALUE (0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .up_down (up_down),
    .counter (counter),
    .at_max  (at_max),
    .at_min  (at_min),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [3:0] exp_cnt,
                             input logic exp_wrap);
    check_val({tag, ".counter"}, 32'(counter), 32'(exp_cnt));
    check_val({tag, ".wrap"},    32'(wrap),    32'(exp_wrap));
    check_val({tag, ".at_max"},  32'(at_max),  32'(exp_cnt == 4'd15));
    check_val({tag, ".at_min"},  32'(at_min),  32'(exp_cnt == 4'd0));
  endtask

  // Pulse reset low between edges and release it away from the clock edge
  task automatic do_reset();
    #3;
    reset = 1'b0;
    #1;
    check_state("rst_pulse", 4'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    up_down  = 1'b0;

    // Test 1: reset asserted before any clock edge, then held two cycles
    #2;
    check_state("t1_pre_edge", 4'd0, 1'b0);
    step();
    step();
    check_state("t1_held", 4'd0, 1'b0);

    // Test 2: release and count down from 0
    reset = 1'b1;
    step();
`ifdef UP_DOWN_COUNTER_SAT_EN
    check_state("t2_first", 4'd0, 1'b1);
    step();
    check_state("t2_second", 4'd0, 1'b1);
`else
    check_state("t2_first", 4'd15, 1'b1);
    step();
    check_state("t2_second", 4'd14, 1'b0);
`endif

    // Test 3: count up 16 edges from 0
    do_reset();
    up_down = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
`ifdef UP_DOWN_COUNTER_SAT_EN
      check_state($sformatf("t3_up%0d", i), (i == 15) ? 4'd15 : 4'(i + 1),
                  i == 15);
`else
      check_state($sformatf("t3_up%0d", i), 4'(i + 1), i == 15);
`endif
    end

    // Test 4: direction change at 7 takes effect on the next edge
    do_reset();
    up_down = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check_state("t4_at7", 4'd7, 1'b0);
    up_down = 1'b0;
    step();
    check_state("t4_down", 4'd6, 1'b0);
    up_down = 1'b1;
    step();
    check_state("t4_up_again", 4'd7, 1'b0);

    // Test 5: reset mid-period while counter is 9
    do_reset();
    up_down = 1'b1;
    for (int i = 0; i < 9; i++) step();
    check_state("t5_at9", 4'd9, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    check_state("t5_async", 4'd0, 1'b0);
    step();
    check_state("t5_held", 4'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Reset clears a pending wrap pulse: reach 15, step up, then reset
    up_down = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check_state("t5_at15", 4'd15, 1'b0);
    step();
`ifdef UP_DOWN_COUNTER_SAT_EN
    check_state("t5_wrap", 4'd15, 1'b1);
`else
    check_state("t5_wrap", 4'd0, 1'b1);
`endif
    #2;
    reset = 1'b0;
    #1;
    check_state("t5_wrap_clr", 4'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Test 6: behaviour at both ends with up_down held
    up_down = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check_state("t6_at15", 4'd15, 1'b0);
`ifdef UP_DOWN_COUNTER_SAT_EN
    for (int i = 0; i < 3; i++) begin
      step();
      check_state($sformatf("t6_hold_max%0d", i), 4'd15, 1'b1);
    end
    do_reset();
    up_down = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_state($sformatf("t6_hold_min%0d", i), 4'd0, 1'b1);
    end
`else
    step();
    check_state("t6_wrap_up", 4'd0, 1'b1);
    step();
    check_state("t6_after", 4'd1, 1'b0);
    up_down = 1'b0;
    step();
    check_state("t6_down1", 4'd0, 1'b0);
    step();
    check_state("t6_wrap_dn", 4'd15, 1'b1);
    step();
    check_state("t6_down2", 4'd14, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
